// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared widths and port-B read owner tags
//
// Contents:
//   ADDR_W  default RAM word-address width
//   DATA_W  default RAM data width
//   tag_t   owner of an in-flight port-B read (TAG_NONE/TAG_FETCH/TAG_DATA)

package ram_port_arbiter_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM signal bundle for the RAM port arbiter
//
// Signals:
//   fetch side : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   data side  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   RAM port A : ena, wea, addra, dia (write port, registered in the arbiter)
//   RAM port B : enb, addrb (registered in the arbiter), dob (registered in the RAM)
// Modports:
//   slave  : the arbiter
//   master : the CPU stages together with the RAM

interface ram_port_arbiter_if #(
    parameter int ADDR_W = ram_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = ram_port_arbiter_pkg::DATA_W
);

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;

    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dob;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ena, wea, addra, dia,
        output enb, addrb,
        input  dob
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ena, wea, addra, dia,
        input  enb, addrb,
        output dob
    );

endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rtl/ram_port_arbiter_rr_pick2.sv - two-way round-robin picker for RAM port B
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_data, req_fetch    port-B read requests (already hazard-filtered)
//   gnt_data, gnt_fetch    combinational one-hot grant
// The pointer remembers which side was granted last; that side loses the
// next tie. It moves on every port-B grant, contested or not, and resets to
// "data last granted".

module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req_data,
    input  logic req_fetch,
    output logic gnt_data,
    output logic gnt_fetch
);

    logic data_last;

    always_comb begin
        gnt_data  = 1'b0;
        gnt_fetch = 1'b0;
        if (req_data && req_fetch) begin
            gnt_data  = !data_last;
            gnt_fetch = data_last;
        end else begin
            gnt_data  = req_data;
            gnt_fetch = req_fetch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_last <= 1'b1;
        end else if (gnt_data) begin
            data_last <= 1'b1;
        end else if (gnt_fetch) begin
            data_last <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares a simple dual-port RAM between fetch and load/store
//
// Ports:
//   clka  single clock for the arbiter and both RAM ports
//   rst   synchronous active-high reset
//   bus   ram_port_arbiter_if.slave: requester handshakes and RAM port A/B
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN  defined: port-B ties alternate via rr_pick2;
//                           undefined: data read always beats fetch read.
// Writes use port A and never contend with fetch. Reads use port B with a
// two-edge return: accept edge T, RAM samples addrb at T+1, rdata/rvalid
// are loaded at T+2.

module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
(
    input  logic                clka,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);

    logic d_wr;
    logic d_rd;
    logic hazard;
    logic f_rd;
    logic pick_d;
    logic pick_f;

    tag_t tag_q1;
    tag_t tag_q2;
    tag_t tag_next;

    assign d_wr = bus.d_req && bus.d_we;
    assign d_rd = bus.d_req && !bus.d_we;

    // A fetch of the word being written this cycle is held off one edge so
    // its port-B read lands after the port-A write has reached the array.
    assign hazard = d_wr && bus.f_req && (bus.f_addr == bus.d_addr);
    assign f_rd   = bus.f_req && !hazard;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    rr_pick2 u_pick (
        .clk       (clka),
        .rst       (rst),
        .req_data  (d_rd),
        .req_fetch (f_rd),
        .gnt_data  (pick_d),
        .gnt_fetch (pick_f)
    );
`else
    assign pick_d = d_rd;
    assign pick_f = f_rd && !d_rd;
`endif

    assign bus.d_gnt = d_wr || pick_d;
    assign bus.f_gnt = pick_f;

    always_comb begin
        tag_next = TAG_NONE;
        if (pick_d) begin
            tag_next = TAG_DATA;
        end else if (pick_f) begin
            tag_next = TAG_FETCH;
        end
    end

    // Port A: one-cycle write strobe; address/data hold when idle.
    always_ff @(posedge clka) begin
        if (rst) begin
            bus.ena   <= 1'b0;
            bus.wea   <= 1'b0;
            bus.addra <= '0;
            bus.dia   <= '0;
        end else begin
            bus.ena <= d_wr;
            bus.wea <= d_wr;
            if (d_wr) begin
                bus.addra <= bus.d_addr;
                bus.dia   <= bus.d_wdata;
            end
        end
    end

    // Port B issue plus the owner-tag pipeline that follows each read
    // through the RAM's output register.
    always_ff @(posedge clka) begin
        if (rst) begin
            bus.enb   <= 1'b0;
            bus.addrb <= '0;
            tag_q1    <= TAG_NONE;
            tag_q2    <= TAG_NONE;
        end else begin
            bus.enb <= pick_d || pick_f;
            if (pick_d) begin
                bus.addrb <= bus.d_addr;
            end else if (pick_f) begin
                bus.addrb <= bus.f_addr;
            end
            tag_q1 <= tag_next;
            tag_q2 <= tag_q1;
        end
    end

    // Return: steer dob to the owner; rdata holds until the owner's next read.
    always_ff @(posedge clka) begin
        if (rst) begin
            bus.f_rvalid <= 1'b0;
            bus.f_rdata  <= '0;
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.f_rvalid <= (tag_q2 == TAG_FETCH);
            bus.d_rvalid <= (tag_q2 == TAG_DATA);
            if (tag_q2 == TAG_FETCH) begin
                bus.f_rdata <= bus.dob;
            end
            if (tag_q2 == TAG_DATA) begin
                bus.d_rdata <= bus.dob;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter

module tb_ram_port_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clka;
    logic rst;
    int   checks;
    int   failures;

    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] mem [0:1023];

    ram_port_arbiter_if #(.ADDR_W(10), .DATA_W(16)) bus ();

    ram_port_arbiter dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // RAM model: write-then-read ordering across edges, registered dob.
    always @(posedge clka) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.ena && bus.wea) begin
            mem[bus.addra] <= bus.dia;
        end
        if (bus.enb) begin
            bus.dob <= mem[bus.addrb];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #2;
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"},    32'(bus.ena),      32'h0);
        check({tag, "_wea"},    32'(bus.wea),      32'h0);
        check({tag, "_addra"},  32'(bus.addra),    32'h0);
        check({tag, "_dia"},    32'(bus.dia),      32'h0);
        check({tag, "_enb"},    32'(bus.enb),      32'h0);
        check({tag, "_addrb"},  32'(bus.addrb),    32'h0);
        check({tag, "_frv"},    32'(bus.f_rvalid), 32'h0);
        check({tag, "_frdata"}, 32'(bus.f_rdata),  32'h0);
        check({tag, "_drv"},    32'(bus.d_rvalid), 32'h0);
        check({tag, "_drdata"}, 32'(bus.d_rdata),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        rst      = 1'b1;
        idle_inputs();

        load(10'd5, 16'h0102);
        load(10'd3, 16'h0033);
        load(10'd4, 16'h0044);
        load(10'd8, 16'h0808);
        load(10'd1, 16'h1111);
        load(10'd2, 16'h2222);
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single fetch read of addr 5
        bus.f_req = 1'b1; bus.f_addr = 10'd5;
        #1 check("t1_fgnt", 32'(bus.f_gnt), 32'h1);
        tick();
        bus.f_req = 1'b0;
        check("t1_enb",   32'(bus.enb),   32'h1);
        check("t1_addrb", 32'(bus.addrb), 32'h5);
        tick();
        check("t1_frv_early", 32'(bus.f_rvalid), 32'h0);
        tick();
        check("t1_frv",   32'(bus.f_rvalid), 32'h1);
        check("t1_frdata", 32'(bus.f_rdata), 32'h0102);
        tick();
        check("t1_frv_pulse", 32'(bus.f_rvalid), 32'h0);
        check("t1_frdata_hold", 32'(bus.f_rdata), 32'h0102);

        // Contended reads: data wins first (pointer last = fetch in RR build)
        bus.f_req = 1'b1; bus.f_addr = 10'd3;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd4;
        #1;
        check("t2_dgnt", 32'(bus.d_gnt), 32'h1);
        check("t2_fgnt0", 32'(bus.f_gnt), 32'h0);
        tick();
        bus.d_req = 1'b0;
        #1 check("t2_fgnt1", 32'(bus.f_gnt), 32'h1);
        check("t2_addrb_d", 32'(bus.addrb), 32'h4);
        tick();
        bus.f_req = 1'b0;
        check("t2_addrb_f", 32'(bus.addrb), 32'h3);
        tick();
        check("t2_drv", 32'(bus.d_rvalid), 32'h1);
        check("t2_drdata", 32'(bus.d_rdata), 32'h0044);
        check("t2_frv_early", 32'(bus.f_rvalid), 32'h0);
        tick();
        check("t2_frv", 32'(bus.f_rvalid), 32'h1);
        check("t2_frdata", 32'(bus.f_rdata), 32'h0033);
        check("t2_drv_off", 32'(bus.d_rvalid), 32'h0);

        // Write 7 with fetch read 8 on the same edge
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd7; bus.d_wdata = 16'h00AA;
        bus.f_req = 1'b1; bus.f_addr = 10'd8;
        #1;
        check("t3_dgnt", 32'(bus.d_gnt), 32'h1);
        check("t3_fgnt", 32'(bus.f_gnt), 32'h1);
        tick();
        idle_inputs();
        check("t3_ena",   32'(bus.ena),   32'h1);
        check("t3_wea",   32'(bus.wea),   32'h1);
        check("t3_addra", 32'(bus.addra), 32'h7);
        check("t3_dia",   32'(bus.dia),   32'h00AA);
        check("t3_addrb", 32'(bus.addrb), 32'h8);
        tick();
        check("t3_wea_off", 32'(bus.wea), 32'h0);
        check("t3_ena_off", 32'(bus.ena), 32'h0);
        check("t3_addra_hold", 32'(bus.addra), 32'h7);
        tick();
        check("t3_frv", 32'(bus.f_rvalid), 32'h1);
        check("t3_frdata", 32'(bus.f_rdata), 32'h0808);
        check("t3_drv", 32'(bus.d_rvalid), 32'h0);

        // Hazard: write BEEF to 9 while fetching 9
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd9; bus.d_wdata = 16'hBEEF;
        bus.f_req = 1'b1; bus.f_addr = 10'd9;
        #1;
        check("t4_fgnt0", 32'(bus.f_gnt), 32'h0);
        check("t4_dgnt",  32'(bus.d_gnt), 32'h1);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1 check("t4_fgnt1", 32'(bus.f_gnt), 32'h1);
        check("t4_addra", 32'(bus.addra), 32'h9);
        tick();
        bus.f_req = 1'b0;
        check("t4_addrb", 32'(bus.addrb), 32'h9);
        tick();
        tick();
        check("t4_frv", 32'(bus.f_rvalid), 32'h1);
        check("t4_frdata", 32'(bus.f_rdata), 32'hBEEF);

        // Continuous contention for six cycles
        bus.f_req = 1'b1; bus.f_addr = 10'd1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t5_dgnt%0d", i), 32'(bus.d_gnt), RR ? 32'(i % 2 == 0) : 32'h1);
            check($sformatf("t5_fgnt%0d", i), 32'(bus.f_gnt), RR ? 32'(i % 2 == 1) : 32'h0);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        tick();
        check("t5_drdata", 32'(bus.d_rdata), 32'h2222);

        // Reset discards an in-flight read
        bus.f_req = 1'b1; bus.f_addr = 10'd5;
        #1 check("t6_fgnt", 32'(bus.f_gnt), 32'h1);
        tick();
        bus.f_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("t6");
        tick();
        check("t6_frv_a", 32'(bus.f_rvalid), 32'h0);
        check("t6_drv_a", 32'(bus.d_rvalid), 32'h0);
        tick();
        check("t6_frv_b", 32'(bus.f_rvalid), 32'h0);
        check("t6_drv_b", 32'(bus.d_rvalid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the simple dual-port instruction/data RAM between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read or write). It sits between the CPU stages and the RAM. It drives the RAM's write port A and read port B, and pipelines port-B reads with a 2-cycle return latency. It resolves port-B contention and the same-address write/read hazard, so the CPU stages never touch RAM enables or addresses directly.

## Interface
- ADDR_W, 10, RAM word-address width
- DATA_W, 16, RAM data width

- clka  in  1  single clock; RAM port A and port B both run on it
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request; hold with f_addr until granted
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  combinational; transfer on rising edge where f_req && f_gnt
- f_rvalid  out  1  one-cycle pulse, fetch read data valid
- f_rdata  out  DATA_W  fetch read data; holds until next f_rvalid
- d_req  in  1  data request; hold with d_we, d_addr and d_wdata until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  combinational grant, same rule as f_gnt
- d_rvalid  out  1  one-cycle pulse, data read valid (reads only)
- d_rdata  out  DATA_W  data read data
- ena, wea  out  1  RAM port A enable/write, registered
- addra  out  ADDR_W  registered
- dia  out  DATA_W  registered
- enb  out  1  RAM port B enable, registered
- addrb  out  ADDR_W  registered
- dob  in  DATA_W  RAM port B output, registered inside RAM

## Operation
- A data write never contends with a fetch read; both may be granted on the same edge.
- A data read and a fetch read contend for port B. The winner is chosen by the arbitration policy (see Configuration).
- Hazard: d_req && d_we && f_req && f_addr == d_addr forces f_gnt=0 that cycle. The fetch is granted on the next edge and returns the newly written word.
- Granted write:
  - next cycle: ena=1, wea=1, addra=d_addr, dia=d_wdata for exactly one cycle
  - no rvalid is produced
- Granted read:
  - next cycle: enb=1, addrb=addr
  - a 2-deep owner-tag pipeline (NONE/FETCH/DATA) tracks the read
  - two edges after the grant, the owning requester's rdata is loaded from dob and its rvalid pulses
- Reads are fully pipelined; one port-B read is accepted per cycle.
- Idle cycles: ena=wea=enb=0. Address and data registers hold their last values.
- Reset clears all outputs to 0, the tag pipeline to NONE, and the round-robin pointer to "data last granted". In-flight reads are discarded, and no rvalid follows a reset edge.

## Timing
- Grant is combinational from req/addr/policy state. No wait state is added when uncontested.
- Read latency:
  - accept edge T → RAM samples addrb at T+1
  - dob valid after T+1
  - rvalid high in cycle following edge T+2
- Write latency: accept edge T → RAM written at edge T+1. A read granted at T+1 or later observes the new data.
- Back-to-back reads from the same requester return in order, one per cycle.
- rst has priority over any simultaneous req.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN
  - defined: port-B ties alternate; the requester granted last loses the next tie. The pointer updates only on contested-or-uncontested port-B grants.
  - undefined: fixed priority, data read beats fetch read; the pointer logic is absent.

## Structure
- Shared package:
  - ADDR_W/DATA_W defaults
  - owner-tag constants TAG_NONE=0, TAG_FETCH=1, TAG_DATA=2
- Sub-module rr_pick2: 2-way picker with its pointer register, instantiated only when RAM_ARB_ROUND_ROBIN_EN is defined.

## Test plan
- ram[5]=0x0102; f_req addr 5 → f_gnt=1 same cycle, enb=1/addrb=5 next cycle, f_rvalid with f_rdata=0x0102 two cycles after accept.
- f_req addr 3 and d_req read addr 4 together, fixed priority (ram[3]=0x0033, ram[4]=0x0044):
  - d granted at edge 0, f at edge 1
  - d_rvalid 0x0044 at +2, f_rvalid 0x0033 at +3
- d write 0x00AA to 7 with f read 8 (ram[8]=0x0808) → both granted same edge; one-cycle wea with addra=7/dia=0x00AA; f_rdata=0x0808.
- Hazard: d write 0xBEEF to 9 with f read 9 → f_gnt=0 that cycle, granted next; f_rdata=0xBEEF.
- Both reading continuously for 6 cycles:
  - with RAM_ARB_ROUND_ROBIN_EN: grants d,f,d,f,d,f
  - without: d granted every cycle, f_gnt stays 0
- Read accepted at edge T, rst at edge T+1 → no f_rvalid/d_rvalid; all outputs 0 after reset edge.
